// File: rtl/cache_mem_responder_if.sv
// Request/response and main-memory signal bundle for the data cache responder.
// The slave modport is the cache side; the master modport is the datapath/memory side.
interface cache_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_is_word;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;
  logic              hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_is_word, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, stall, hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_is_word, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, stall, hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Direct-mapped write-back data cache with one-word lines serving LW/LB/SW/SB.
// Misses write back a dirty victim, refill from memory, then complete in COMPARE.
module cache_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_mem_responder_if.slave bus
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  addr_p0;
  logic               we_p0;
  logic               word_p0;
  logic [DATA_W-1:0]  wdata_p0;

  logic [DATA_W-1:0]  line_data [LINES];
  logic [TAG_W-1:0]   line_tag  [LINES];
  logic [LINES-1:0]   line_valid;
  logic [LINES-1:0]   line_dirty;

  logic [TAG_W-1:0]   tag_p0;
  logic [INDEX_W-1:0] idx_p0;
  logic [1:0]         lane_p0;
  logic [DATA_W-1:0]  cur_data;
  logic [TAG_W-1:0]   cur_tag;
  logic               tag_match;

  logic               accept;
  logic               data_we;
  logic [DATA_W-1:0]  data_wval;
  logic               fill;
  logic               set_dirty;
  logic               clr_dirty;

  logic               req_ready;
  logic               resp_valid;
  logic [DATA_W-1:0]  resp_rdata;
  logic               hit;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  function automatic logic [DATA_W-1:0] sext_byte(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] lane);
    logic signed [7:0] b;
    b = w[{lane, 3'b000} +: 8];
    return DATA_W'(b);
  endfunction

  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] w,
                                                   input logic [7:0] b,
                                                   input logic [1:0] lane);
    logic [DATA_W-1:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign tag_p0    = addr_p0[ADDR_W-1:INDEX_W+2];
  assign idx_p0    = addr_p0[INDEX_W+1:2];
  assign lane_p0   = addr_p0[1:0];
  assign cur_data  = line_data[idx_p0];
  assign cur_tag   = line_tag[idx_p0];
  assign tag_match = line_valid[idx_p0] && (cur_tag == tag_p0);

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    hit        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    accept     = 1'b0;
    data_we    = 1'b0;
    data_wval  = cur_data;
    fill       = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (tag_match) begin
          hit        = 1'b1;
          resp_valid = 1'b1;
          state_nxt  = IDLE;
          if (we_p0) begin
            data_we   = 1'b1;
            data_wval = word_p0 ? wdata_p0 : merge_byte(cur_data, wdata_p0[7:0], lane_p0);
            set_dirty = 1'b1;
          end else begin
            resp_rdata = word_p0 ? cur_data : sext_byte(cur_data, lane_p0);
          end
        end else begin
          state_nxt = line_dirty[idx_p0] ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        // Victim address comes from the stored tag, which cannot change until the ack.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cur_tag, idx_p0, 2'b00};
        mem_wdata = cur_data;
        if (bus.mem_ack) begin
          clr_dirty = 1'b1;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_p0, idx_p0, 2'b00};
        if (bus.mem_ack) begin
          fill      = 1'b1;
          data_we   = 1'b1;
          data_wval = bus.mem_rdata;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM and per-line valid/dirty bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_valid <= '0;
      line_dirty <= '0;
    end else begin
      state <= state_nxt;
      if (fill) begin
        line_valid[idx_p0] <= 1'b1;
        line_dirty[idx_p0] <= 1'b0;
      end else if (clr_dirty) begin
        line_dirty[idx_p0] <= 1'b0;
      end else if (set_dirty) begin
        line_dirty[idx_p0] <= 1'b1;
      end
    end
  end

  // Data state: latched request and line storage, qualified by the control bits
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= bus.req_addr;
      we_p0    <= bus.req_we;
      word_p0  <= bus.req_is_word;
      wdata_p0 <= bus.req_wdata;
    end
    if (data_we) line_data[idx_p0] <= data_wval;
    if (fill)    line_tag[idx_p0]  <= tag_p0;
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.hit        = hit;
  assign bus.stall      = (state != IDLE) && !resp_valid;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: hits, byte lanes, evictions, memory
// handshake hold and reset during a refill, with a small memory responder.
module tb_cache_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        txlog[$];
  logic [31:0] mem [logic [31:0]];

  cache_mem_responder_if bus ();

  cache_mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5A00_0000 | a;
  endfunction

  // One access from IDLE to resp_valid, answering memory after lat waiting cycles.
  task automatic access(input logic we, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input bit hold_chk,
                        output logic [31:0] rdata, output int cycles, output logic hit_seen);
    int          waitc;
    int          guard;
    bit          seen;
    logic [31:0] a0;
    logic        st0;
    txlog.delete();
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid   = 1'b1;
    bus.req_we      = we;
    bus.req_is_word = w;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cycles = 1;
    waitc  = 0;
    seen   = 0;
    a0     = '0;
    st0    = 1'b0;
    while (!bus.resp_valid && cycles < 200) begin
      if (bus.mem_req) begin
        if (!seen) begin
          a0   = bus.mem_addr;
          st0  = bus.stall;
          seen = 1;
        end else if (hold_chk) begin
          check("hold_mem_req", bus.mem_req, 1);
          check("hold_mem_addr", bus.mem_addr, a0);
          check("hold_stall", bus.stall, st0);
        end
        if (hold_chk) begin
          bus.req_valid   = waitc[0];
          bus.req_we      = 1'b1;
          bus.req_is_word = 1'b1;
          bus.req_addr    = a;
          bus.req_wdata   = 32'h0;
        end
        if (waitc == lat) begin
          bus.req_valid = 1'b0;
          bus.mem_ack   = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = rd(bus.mem_addr);
          txlog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
          waitc = 0;
          seen  = 0;
        end else begin
          waitc++;
        end
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      cycles++;
    end
    bus.req_valid = 1'b0;
    check("resp_timeout", bus.resp_valid, 1);
    rdata    = bus.resp_rdata;
    hit_seen = bus.hit;
  endtask

  initial begin
    logic [31:0] r;
    int          c;
    logic        h;

    rst_n           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_is_word = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    mem[32'h40]     = 32'hDEAD_BEEF;
    mem[32'h440]    = 32'hCAFE_F00D;
    mem[32'h4]      = 32'h0BAD_CAFE;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_mem_req", bus.mem_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 32'h40, 32'h0, 2, 0, r, c, h);
    check("cold_rdata", r, 32'hDEAD_BEEF);
    check("cold_txn_count", txlog.size(), 1);
    if (txlog.size() > 0) begin
      check("cold_txn_we", txlog[0].we, 0);
      check("cold_txn_addr", txlog[0].addr, 32'h40);
    end
    check("cold_not_single_cycle", c > 1, 1);

    access(1'b0, 1'b1, 32'h40, 32'h0, 2, 0, r, c, h);
    check("hit_rdata", r, 32'hDEAD_BEEF);
    check("hit_latency", c, 1);
    check("hit_flag", h, 1);
    check("hit_no_mem", txlog.size(), 0);

    access(1'b1, 1'b0, 32'h41, 32'h80, 2, 0, r, c, h);
    check("sb_rdata_zero", r, 0);
    check("sb_latency", c, 1);
    access(1'b0, 1'b0, 32'h41, 32'h0, 2, 0, r, c, h);
    check("lb_sext_neg", r, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 32'h40, 32'h0, 2, 0, r, c, h);
    check("lw_after_sb", r, 32'hDEAD_80EF);

    access(1'b1, 1'b0, 32'h43, 32'h1234_5677, 2, 0, r, c, h);
    access(1'b0, 1'b0, 32'h43, 32'h0, 2, 0, r, c, h);
    check("lb_lane3_pos", r, 32'h0000_0077);
    access(1'b0, 1'b0, 32'h40, 32'h0, 2, 0, r, c, h);
    check("lb_lane0", r, 32'hFFFF_FFEF);

    access(1'b1, 1'b1, 32'h40, 32'h1111_2222, 2, 0, r, c, h);
    check("sw_latency", c, 1);
    access(1'b0, 1'b1, 32'h440, 32'h0, 1, 0, r, c, h);
    check("evict_rdata", r, 32'hCAFE_F00D);
    check("evict_txn_count", txlog.size(), 2);
    if (txlog.size() == 2) begin
      check("evict_wb_we", txlog[0].we, 1);
      check("evict_wb_addr", txlog[0].addr, 32'h40);
      check("evict_wb_data", txlog[0].data, 32'h1111_2222);
      check("evict_rf_we", txlog[1].we, 0);
      check("evict_rf_addr", txlog[1].addr, 32'h440);
    end
    access(1'b0, 1'b1, 32'h40, 32'h0, 1, 0, r, c, h);
    check("writeback_readback", r, 32'h1111_2222);
    check("clean_victim_txn_count", txlog.size(), 1);

    access(1'b0, 1'b1, 32'h80, 32'h0, 0, 0, r, c, h);
    check("clean_lw80_rdata", r, 32'h5A00_0080);
    access(1'b0, 1'b1, 32'h480, 32'h0, 0, 0, r, c, h);
    check("clean_lw480_rdata", r, 32'h5A00_0480);
    check("clean_evict_count", txlog.size(), 1);
    if (txlog.size() > 0) begin
      check("clean_evict_we", txlog[0].we, 0);
      check("clean_evict_addr", txlog[0].addr, 32'h480);
    end

    access(1'b0, 1'b1, 32'h4, 32'h0, 10, 1, r, c, h);
    check("hold_rdata", r, 32'h0BAD_CAFE);
    check("hold_txn_count", txlog.size(), 1);
    access(1'b0, 1'b1, 32'h4, 32'h0, 0, 0, r, c, h);
    check("hold_ignored_req", r, 32'h0BAD_CAFE);
    check("hold_then_hit", c, 1);

    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_we      = 1'b0;
    bus.req_is_word = 1'b1;
    bus.req_addr    = 32'h8;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("midrefill_mem_req", bus.mem_req, 1);
    check("midrefill_mem_addr", bus.mem_addr, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", bus.mem_req, 0);
    check("async_rst_req_ready", bus.req_ready, 1);
    check("async_rst_stall", bus.stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0001;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    check("stale_ack_ready", bus.req_ready, 1);
    check("stale_ack_resp", bus.resp_valid, 0);
    check("stale_ack_mem_req", bus.mem_req, 0);
    access(1'b0, 1'b1, 32'h8, 32'h0, 0, 0, r, c, h);
    check("post_rst_rdata", r, 32'h5A00_0008);
    check("post_rst_miss", txlog.size(), 1);
    access(1'b0, 1'b1, 32'h480, 32'h0, 0, 0, r, c, h);
    check("post_rst_valid_cleared", txlog.size(), 1);
    check("post_rst_lw480", r, 32'h5A00_0480);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
